// File: rtl/seg7_scan_display_if.sv
// Bundle between the timer (digit source and display sink) and the
// multiplexed 7-segment scan driver.
interface seg7_scan_display_if;
  logic [1:0] hour1;
  logic [3:0] hour0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hour1, hour0, min1, min0, blank_lead,
    input  an, seg, dp
  );

  modport slave (
    input  hour1, hour0, min1, min0, blank_lead,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit common-anode 7-segment scan driver with a per-frame time snapshot,
// 1 Hz blinking colon on the hour0 digit and optional leading-zero blanking.
module seg7_scan_display #(
  parameter int DIGIT_CYCLES    = 50000,
  parameter int HALF_SEC_CYCLES = 25000000
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_display_if.slave disp
);
  localparam int RW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BW = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(DIGIT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(HALF_SEC_CYCLES - 1);

  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [1:0]    snap_h1_q, snap_h1_d;
  logic [3:0]    snap_h0_q, snap_h0_d;
  logic [2:0]    snap_m1_q, snap_m1_d;
  logic [3:0]    snap_m0_q, snap_m0_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          digit_tick;
  logic          blink_tick;
  logic [3:0]    sel_digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    digit_tick = (refresh_q == REFRESH_LAST);
    blink_tick = (blink_q == BLINK_LAST);

    refresh_d = digit_tick ? '0 : refresh_q + 1'b1;
    idx_d     = digit_tick ? idx_q + 2'd1 : idx_q;
    blink_d   = blink_tick ? '0 : blink_q + 1'b1;
    phase_d   = blink_tick ? ~phase_q : phase_q;

    snap_h1_d = snap_h1_q;
    snap_h0_d = snap_h0_q;
    snap_m1_d = snap_m1_q;
    snap_m0_d = snap_m0_q;
    // Capture the whole time at once on the frame wrap so a frame never mixes two times.
    if (digit_tick && idx_q == 2'd3) begin
      snap_h1_d = disp.hour1;
      snap_h0_d = disp.hour0;
      snap_m1_d = disp.min1;
      snap_m0_d = disp.min0;
    end

    case (idx_q)
      2'd0:    sel_digit = snap_m0_q;
      2'd1:    sel_digit = {1'b0, snap_m1_q};
      2'd2:    sel_digit = snap_h0_q;
      default: sel_digit = {2'b00, snap_h1_q};
    endcase

    an_d = ~(4'b0001 << idx_q);
    if (idx_q == 2'd3 && disp.blank_lead && snap_h1_q == 2'd0) begin
      an_d = 4'b1111;
    end
    seg_d = decode(sel_digit);
    dp_d  = !(idx_q == 2'd2 && phase_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      blink_q   <= '0;
      phase_q   <= 1'b1;
      snap_h1_q <= '0;
      snap_h0_q <= '0;
      snap_m1_q <= '0;
      snap_m0_q <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      snap_h1_q <= snap_h1_d;
      snap_h0_q <= snap_h0_d;
      snap_m1_q <= snap_m1_d;
      snap_m0_q <= snap_m0_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized bench for seg7_scan_display: a cycle-count based model of the scan,
// blink and snapshot rules is compared every cycle, plus literal pinning checks.
module tb_seg7_scan_display;
  localparam int D = 4;
  localparam int H = 16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   edges;
  logic [3:0] snap [4];

  seg7_scan_display_if bus();

  seg7_scan_display #(
    .DIGIT_CYCLES(D),
    .HALF_SEC_CYCLES(H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .disp(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ean,
                             input logic [6:0] eseg, input logic edp);
    checkVal({name, "_an"}, int'(bus.an), int'(ean));
    checkVal({name, "_seg"}, int'(bus.seg), int'(eseg));
    checkVal({name, "_dp"}, int'(bus.dp), int'(edp));
  endtask

  task automatic applyStimulus(input int h1, input int h0, input int m1,
                               input int m0, input int bl);
    bus.hour1      = 2'(h1);
    bus.hour0      = 4'(h0);
    bus.min1       = 3'(m1);
    bus.min0       = 4'(m0);
    bus.blank_lead = 1'(bl);
  endtask

  task automatic applyRandom();
    applyStimulus($urandom_range(3), $urandom_range(15), $urandom_range(7),
                  $urandom_range(15), $urandom_range(1));
  endtask

  task automatic stepTo(input int target);
    int g;
    g = 0;
    while (edges < target) begin
      if (g > 200) begin
        checkVal("stepTo_timeout", edges, target);
        return;
      end
      @(posedge clk);
      #2;
      g++;
    end
  endtask

  // Model: after e-1 elapsed edges the slot is ((e-1)/D)%4 and the colon is lit
  // during even half-periods; the snapshot is reloaded every 4*D edges.
  always @(posedge clk) begin
    int         e;
    int         idx;
    bit         ph;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    if (rst) begin
      edges = 0;
      for (int i = 0; i < 4; i++) snap[i] = 4'd0;
      #1;
      checkOutput("in_reset", 4'b1111, 7'b1111111, 1'b1);
    end else begin
      e    = edges + 1;
      idx  = ((e - 1) / D) % 4;
      ph   = (((e - 1) / H) % 2) == 0;
      ean  = 4'b1111;
      if (!(idx == 3 && bus.blank_lead && snap[3] == 4'd0)) ean[idx] = 1'b0;
      eseg = segOf(snap[idx]);
      edp  = !(idx == 2 && ph);
      if (e % (4 * D) == 0) begin
        snap[0] = bus.min0;
        snap[1] = {1'b0, bus.min1};
        snap[2] = bus.hour0;
        snap[3] = {2'b00, bus.hour1};
      end
      edges = e;
      #1;
      checkOutput("model", ean, eseg, edp);
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    edges = 0;
    rst   = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset", 4'b1111, 7'b1111111, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 2, 3, 4, 0);

    stepTo(1);  checkOutput("f0_s0", 4'b1110, 7'b1000000, 1'b1);
    stepTo(5);  checkOutput("f0_s1", 4'b1101, 7'b1000000, 1'b1);
    stepTo(9);  checkOutput("f0_s2", 4'b1011, 7'b1000000, 1'b0);
    stepTo(13); checkOutput("f0_s3", 4'b0111, 7'b1000000, 1'b1);
    stepTo(17); checkOutput("f1_s0", 4'b1110, 7'b0011001, 1'b1);
    stepTo(21); checkOutput("f1_s1", 4'b1101, 7'b0110000, 1'b1);
    stepTo(25); checkOutput("f1_s2", 4'b1011, 7'b0100100, 1'b1);
    stepTo(29); checkOutput("f1_s3", 4'b0111, 7'b1111001, 1'b1);

    stepTo(41); checkOutput("f2_s2", 4'b1011, 7'b0100100, 1'b0);
    applyStimulus(1, 2, 3, 7, 0);
    stepTo(42); checkOutput("f2_s2b", 4'b1011, 7'b0100100, 1'b0);
    stepTo(45); checkOutput("f2_s3", 4'b0111, 7'b1111001, 1'b1);
    stepTo(49); checkOutput("f3_s0", 4'b1110, 7'b1111000, 1'b1);

    applyStimulus(0, 12, 3, 7, 1);
    stepTo(73); checkOutput("bad_digit", 4'b1011, 7'b1111111, 1'b0);
    stepTo(77); checkOutput("blank_on", 4'b1111, 7'b1000000, 1'b1);
    applyStimulus(0, 12, 3, 7, 0);
    stepTo(78); checkOutput("blank_off", 4'b0111, 7'b1000000, 1'b1);

    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(3) == 0) applyRandom();
    end

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 4'b1111, 7'b1111111, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(2) == 0) applyRandom();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
